// File: rtl/sdrc_arb_pkg.sv
// Shared types and constants for the sdrc_top Wishbone arbiter.
// Holds the arbiter state encoding and the Wishbone cycle-type codes.
package sdrc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/sdrc_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_ptr,
// searching upward and wrapping modulo NUM_M.
module sdrc_rr_picker #(
  parameter int NUM_M = 2,
  parameter int GIW   = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [GIW-1:0]   last_ptr,
  output logic [GIW-1:0]   winner,
  output logic             any_req
);

  logic [GIW-1:0]     start;
  logic [2*NUM_M-1:0] dbl;
  logic [NUM_M-1:0]   rot;
  logic [GIW-1:0]     off;
  logic [GIW:0]       sum;

  // Rotate so that bit 0 of rot is the master just after last_ptr.
  assign start   = (last_ptr == GIW'(NUM_M - 1)) ? '0 : last_ptr + 1'b1;
  assign dbl     = {req, req};
  assign rot     = dbl[start +: NUM_M];
  assign any_req = |req;

  always_comb begin
    off = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (rot[i]) off = GIW'(i);
    end
  end

  // Undo the rotation, wrapping back into 0..NUM_M-1.
  always_comb begin
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (GIW+1)'(NUM_M)) winner = GIW'(sum - (GIW+1)'(NUM_M));
    else                        winner = sum[GIW-1:0];
  end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the sdrc_top slave port between NUM_M
// masters; a grant is held for as long as the owner keeps cyc asserted.
module sdrc_wb_arbiter
  import sdrc_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SW    = 4,
  parameter int GIW   = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_resetn,
  input  logic [NUM_M-1:0]    m_cyc_i,
  input  logic [NUM_M-1:0]    m_stb_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_dat_i,
  input  logic [NUM_M*SW-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0]  m_cti_i,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [DW-1:0]       m_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_dat_o,
  output logic [SW-1:0]       s_sel_o,
  output logic [2:0]          s_cti_o,
  input  logic                s_ack_i,
  input  logic [DW-1:0]       s_dat_i,
  output logic [NUM_M-1:0]    gnt_o,
  output logic                busy_o
);

  // Handshake: the owner's cyc/stb pass straight to sdrc_top; a beat completes
  // on a cycle where s_ack_i is high, and that ack is steered only to the owner.

  arb_state_t     state;
  logic [GIW-1:0] gidx;
  logic [GIW-1:0] last_ptr;
  logic [GIW-1:0] winner;
  logic           any_req;
  int             gi;

  sdrc_rr_picker #(
    .NUM_M (NUM_M),
    .GIW   (GIW)
  ) u_picker (
    .req      (m_cyc_i),
    .last_ptr (last_ptr),
    .winner   (winner),
    .any_req  (any_req)
  );

  // last_ptr resets to the top index so master 0 wins the first arbitration.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_resetn) begin
      state    <= IDLE;
      gnt_o    <= '0;
      gidx     <= '0;
      last_ptr <= GIW'(NUM_M - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_o <= NUM_M'(1) << winner;
            gidx  <= winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!m_cyc_i[gidx]) begin
            last_ptr <= gidx;
            gnt_o    <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state == GRANT);
  assign gi     = int'(gidx);

  // Slave-side mux driven from the registered owner index; quiet while IDLE.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    if (state == GRANT) begin
      s_cyc_o  = m_cyc_i[gidx];
      s_stb_o  = m_stb_i[gidx] & m_cyc_i[gidx];
      s_we_o   = m_we_i[gidx];
      s_addr_o = m_addr_i[gi*AW +: AW];
      s_dat_o  = m_dat_i[gi*DW +: DW];
      s_sel_o  = m_sel_i[gi*SW +: SW];
      s_cti_o  = m_cti_i[gi*3 +: 3];
    end
  end

  // gnt_o is zero in IDLE, so a stray ack there never reaches a master.
  assign m_ack_o = {NUM_M{s_ack_i}} & gnt_o & m_cyc_i;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Directed bench for sdrc_wb_arbiter with two masters: a per-cycle vector
// table followed by hand-written burst and reset-mid-burst sequences.
module tb_sdrc_wb_arbiter;
  import sdrc_arb_pkg::*;

  localparam int NUM_M = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int GIW   = 1;

  logic                clk;
  logic                rst_n;
  logic [NUM_M-1:0]    m_cyc, m_stb, m_we, m_ack;
  logic [AW-1:0]       addr_m [NUM_M];
  logic [DW-1:0]       dat_m  [NUM_M];
  logic [SW-1:0]       sel_m  [NUM_M];
  logic [2:0]          cti_m  [NUM_M];
  logic [DW-1:0]       m_dat_o;
  logic                s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_dat_o, s_dat_i;
  logic [SW-1:0]       s_sel;
  logic [2:0]          s_cti;
  logic [NUM_M-1:0]    gnt;
  logic                busy;

  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdrc_wb_arbiter #(
    .NUM_M (NUM_M), .AW (AW), .DW (DW), .SW (SW), .GIW (GIW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_resetn (rst_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_addr_i  ({addr_m[1], addr_m[0]}),
    .m_dat_i   ({dat_m[1], dat_m[0]}),
    .m_sel_i   ({sel_m[1], sel_m[0]}),
    .m_cti_i   ({cti_m[1], cti_m[0]}),
    .m_ack_o   (m_ack),
    .m_dat_o   (m_dat_o),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel),
    .s_cti_o   (s_cti),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_dat_i),
    .gnt_o     (gnt),
    .busy_o    (busy)
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       sack;
    logic [1:0] gnt;
    logic       scyc;
    logic       sstb;
    logic [1:0] mack;
    logic       busy;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic a, input logic [1:0] g, input logic sc,
                              input logic ss, input logic [1:0] ma, input logic b);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.sack = a; v.gnt = g;
    v.scyc = sc; v.sstb = ss; v.mack = ma; v.busy = b;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic [1:0] s, input logic a);
    @(negedge clk);
    rst_n = r; m_cyc = c; m_stb = s; s_ack = a;
    s_dat_i = $urandom();
    #1;
  endtask

  task automatic check_owner_slices(input string tag, input logic [1:0] g, input logic b);
    int o;
    o = g[1] ? 1 : 0;
    if (b) begin
      check({tag, "_s_addr"}, 64'(s_addr), 64'(addr_m[o]));
      check({tag, "_s_dat"},  64'(s_dat_o), 64'(dat_m[o]));
      check({tag, "_s_sel"},  64'(s_sel), 64'(sel_m[o]));
      check({tag, "_s_we"},   64'(s_we), 64'(m_we[o]));
      check({tag, "_s_cti"},  64'(s_cti), 64'(cti_m[o]));
    end else begin
      check({tag, "_s_addr_idle"}, 64'(s_addr), 64'(0));
      check({tag, "_s_we_idle"},   64'(s_we), 64'(0));
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_dat_i = '0;
    m_we = 2'b10;
    addr_m[0] = 32'h0000_0100; dat_m[0] = 32'hDEAD_0000; sel_m[0] = 4'h3; cti_m[0] = CTI_CLASSIC;
    addr_m[1] = 32'h0000_0040; dat_m[1] = 32'hA5A5_1234; sel_m[1] = 4'hF; cti_m[1] = CTI_CLASSIC;

    //              rst cyc    stb    ack  gnt   scyc sstb mack  busy
    vecs[0]  = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[1]  = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[2]  = mk(0, 2'b11, 2'b11, 1, 2'b00, 0, 0, 2'b00, 0);
    vecs[3]  = mk(0, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[4]  = mk(1, 2'b11, 2'b11, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[5]  = mk(1, 2'b11, 2'b11, 1, 2'b01, 1, 1, 2'b01, 1);
    vecs[6]  = mk(1, 2'b10, 2'b10, 0, 2'b01, 0, 0, 2'b00, 1);
    vecs[7]  = mk(1, 2'b11, 2'b11, 1, 2'b00, 0, 0, 2'b00, 0);
    vecs[8]  = mk(1, 2'b11, 2'b11, 1, 2'b10, 1, 1, 2'b10, 1);
    vecs[9]  = mk(1, 2'b01, 2'b01, 0, 2'b10, 0, 0, 2'b00, 1);
    vecs[10] = mk(1, 2'b01, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[11] = mk(1, 2'b01, 2'b01, 1, 2'b01, 1, 1, 2'b01, 1);
    vecs[12] = mk(1, 2'b00, 2'b00, 0, 2'b01, 0, 0, 2'b00, 1);
    vecs[13] = mk(1, 2'b00, 2'b00, 1, 2'b00, 0, 0, 2'b00, 0);
    vecs[14] = mk(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[15] = mk(1, 2'b10, 2'b10, 1, 2'b10, 1, 1, 2'b10, 1);
    vecs[16] = mk(1, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b00, 1);
    vecs[17] = mk(1, 2'b10, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0);
    vecs[18] = mk(1, 2'b10, 2'b00, 1, 2'b10, 1, 0, 2'b10, 1);
    vecs[19] = mk(1, 2'b10, 2'b10, 0, 2'b10, 1, 1, 2'b00, 1);
    vecs[20] = mk(1, 2'b00, 2'b10, 0, 2'b10, 0, 0, 2'b00, 1);
    vecs[21] = mk(1, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0);

    // Two unchecked reset cycles bring the registers out of X.
    drive(0, 2'b11, 2'b11, 0);
    drive(0, 2'b11, 2'b11, 0);

    for (int i = 0; i < 22; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].sack);
      check({tag, "_gnt"},   64'(gnt),   64'(vecs[i].gnt));
      check({tag, "_s_cyc"}, 64'(s_cyc), 64'(vecs[i].scyc));
      check({tag, "_s_stb"}, 64'(s_stb), 64'(vecs[i].sstb));
      check({tag, "_m_ack"}, 64'(m_ack), 64'(vecs[i].mack));
      check({tag, "_busy"},  64'(busy),  64'(vecs[i].busy));
      check({tag, "_m_dat"}, 64'(m_dat_o), 64'(s_dat_i));
      check_owner_slices(tag, vecs[i].gnt, vecs[i].busy);
    end

    // Burst atomicity: master 0 bursts 4 beats while master 1 keeps requesting.
    m_we = 2'b00;
    drive(1, 2'b11, 2'b11, 0);
    check("burst_idle_gnt", 64'(gnt), 64'(2'b00));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      addr_m[0] = 32'h0000_0100 + 32'(4 * k);
      cti_m[0]  = (k < 3) ? CTI_INCR : CTI_EOB;
      m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
      s_dat_i = $urandom();
      exp_q.push_back(s_dat_i);
      #1;
      check($sformatf("burst_b%0d_gnt", k), 64'(gnt), 64'(2'b01));
      check($sformatf("burst_b%0d_ack", k), 64'(m_ack), 64'(2'b01));
      check($sformatf("burst_b%0d_addr", k), 64'(s_addr), 64'(32'h100 + 32'(4 * k)));
      check($sformatf("burst_b%0d_cti", k), 64'(s_cti), 64'((k < 3) ? CTI_INCR : CTI_EOB));
      if (m_ack[0] && exp_q.size() > 0) begin
        check($sformatf("burst_b%0d_rdata", k), 64'(m_dat_o), 64'(exp_q.pop_front()));
      end
    end
    check("burst_q_empty", 64'(exp_q.size()), 64'(0));
    drive(1, 2'b10, 2'b10, 0);
    check("burst_drop_gnt", 64'(gnt), 64'(2'b01));
    check("burst_drop_scyc", 64'(s_cyc), 64'(0));
    drive(1, 2'b10, 2'b10, 0);
    check("burst_gap_gnt", 64'(gnt), 64'(2'b00));
    check("burst_gap_busy", 64'(busy), 64'(0));

    // Master 1 write burst, reset lands on beat 2.
    m_we = 2'b10; cti_m[1] = CTI_INCR;
    drive(1, 2'b10, 2'b10, 1);
    check("m1_b1_gnt", 64'(gnt), 64'(2'b10));
    check("m1_b1_ack", 64'(m_ack), 64'(2'b10));
    check("m1_b1_addr", 64'(s_addr), 64'(32'h40));
    check("m1_b1_cti", 64'(s_cti), 64'(CTI_INCR));
    drive(0, 2'b10, 2'b10, 1);
    check("m1_b2_scyc", 64'(s_cyc), 64'(1));
    drive(1, 2'b11, 2'b11, 0);
    check("rst_mid_scyc", 64'(s_cyc), 64'(0));
    check("rst_mid_gnt", 64'(gnt), 64'(2'b00));
    check("rst_mid_busy", 64'(busy), 64'(0));
    drive(1, 2'b11, 2'b11, 0);
    check("rst_mid_rearb", 64'(gnt), 64'(2'b01));

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
